// File: rtl/dm_responder_pkg.sv
//==============================================================================
// Module : dm_responder_pkg
// Brief  : Shared load/store encodings and data-memory constants.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package dm_responder_pkg;

    // Access-size encodings driven by instruction decode on ls_op.
    localparam logic [1:0] c_LS_W = 2'b00;
    localparam logic [1:0] c_LS_H = 2'b01;
    localparam logic [1:0] c_LS_B = 2'b10;

    localparam logic [31:0] c_DM_BASE  = 32'h0000_0000;
    localparam int          c_DM_DEPTH = 3072;

endpackage

`default_nettype wire

// File: rtl/dm_responder_if.sv
//==============================================================================
// Module : dm_responder_if
// Brief  : Load/store request, load response and write-trace bundle.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface dm_responder_if;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  ls_op;
    logic        ld_unsigned;

    logic [31:0] rdata;
    logic        misalign;
    logic        out_of_range;
    logic        err_sticky;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  trace_be;

    modport master (
        output pc, addr, wdata, mem_write, mem_read, ls_op, ld_unsigned,
        input  rdata, misalign, out_of_range, err_sticky,
        input  trace_valid, trace_pc, trace_addr, trace_data, trace_be
    );

    modport slave (
        input  pc, addr, wdata, mem_write, mem_read, ls_op, ld_unsigned,
        output rdata, misalign, out_of_range, err_sticky,
        output trace_valid, trace_pc, trace_addr, trace_data, trace_be
    );
endinterface

`default_nettype wire

// File: rtl/dm_responder_load_ext.sv
//==============================================================================
// Module : dm_load_ext
// Brief  : Selects the byte/half/word lane of a memory word and extends it.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module dm_load_ext
    import dm_responder_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [1:0]  i_lane,
    input  wire logic [1:0]  i_ls_op,
    input  wire logic        i_ld_unsigned,
    output logic      [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    // Halfword lane is chosen by bit 1 only; bit 0 is caught as misalignment upstream.
    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = i_word;
        case (i_ls_op)
            c_LS_B:  o_data = i_ld_unsigned ? {24'h0, w_byte}
                                            : {{24{w_byte[7]}}, w_byte};
            c_LS_H:  o_data = i_ld_unsigned ? {16'h0, w_half}
                                            : {{16{w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dm_responder.sv
//==============================================================================
// Module : dm_responder
// Brief  : Single-cycle data memory with lane stores, extended loads, fault
//          flags and a one-cycle registered write trace.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH = c_DM_DEPTH,
    parameter int IDX_W = 12
)(
    input  wire logic   clk,
    input  wire logic   reset,
    dm_responder_if.slave bus
);

    localparam logic [IDX_W:0] c_DEPTH_V = DEPTH[IDX_W:0];

    logic [31:0]      r_mem [0:DEPTH-1];

    logic             r_trace_valid;
    logic [31:0]      r_trace_pc;
    logic [31:0]      r_trace_addr;
    logic [31:0]      r_trace_data;
    logic [3:0]       r_trace_be;
    logic             r_err_sticky;

    logic             w_access;
    logic [IDX_W-1:0] w_index;
    logic             w_idx_ok;
    logic             w_hi_nz;
    logic             w_out_of_range;
    logic             w_misalign;
    logic             w_commit;
    logic [3:0]       w_be;
    logic [31:0]      w_shift_data;
    logic [31:0]      w_old_word;
    logic [31:0]      w_merged;
    logic [31:0]      w_ext_data;

    assign w_access = bus.mem_write | bus.mem_read;
    assign w_index  = bus.addr[IDX_W+1:2];
    assign w_idx_ok = ({1'b0, w_index} < c_DEPTH_V);
    assign w_hi_nz  = |bus.addr[31:IDX_W+2];

    assign w_out_of_range = w_access & (w_hi_nz | ~w_idx_ok);
    assign w_misalign     = w_access &
                            (((bus.ls_op == c_LS_W) & (bus.addr[1:0] != 2'b00)) |
                             ((bus.ls_op == c_LS_H) & bus.addr[0]));
    assign w_commit       = bus.mem_write & ~w_misalign & ~w_out_of_range;

    // Replicating the store data puts the right bytes on every candidate lane,
    // so the byte enables alone decide which lanes are overwritten.
    always_comb begin
        w_be         = 4'b1111;
        w_shift_data = bus.wdata;
        case (bus.ls_op)
            c_LS_H: begin
                w_be         = 4'b0011 << bus.addr[1:0];
                w_shift_data = {2{bus.wdata[15:0]}};
            end
            c_LS_B: begin
                w_be         = 4'b0001 << bus.addr[1:0];
                w_shift_data = {4{bus.wdata[7:0]}};
            end
            default: begin
                w_be         = 4'b1111;
                w_shift_data = bus.wdata;
            end
        endcase
    end

    assign w_old_word = w_idx_ok ? r_mem[w_index] : 32'h0;

    always_comb begin
        w_merged = w_old_word;
        for (int l = 0; l < 4; l++) begin
            if (w_be[l]) begin
                w_merged[l*8 +: 8] = w_shift_data[l*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (w_commit) begin
            r_mem[w_index] <= w_merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trace_valid <= 1'b0;
            r_trace_pc    <= 32'h0;
            r_trace_addr  <= 32'h0;
            r_trace_data  <= 32'h0;
            r_trace_be    <= 4'h0;
            r_err_sticky  <= 1'b0;
        end else begin
            r_trace_valid <= w_commit;
            r_err_sticky  <= r_err_sticky | w_misalign | w_out_of_range;
            if (w_commit) begin
                r_trace_pc   <= bus.pc;
                r_trace_addr <= {bus.addr[31:2], 2'b00};
                r_trace_data <= w_merged;
                r_trace_be   <= w_be;
            end
        end
    end

    dm_load_ext u_load_ext (
        .i_word        (w_old_word),
        .i_lane        (bus.addr[1:0]),
        .i_ls_op       (bus.ls_op),
        .i_ld_unsigned (bus.ld_unsigned),
        .o_data        (w_ext_data)
    );

    assign bus.rdata        = (bus.mem_read & ~w_misalign & ~w_out_of_range) ? w_ext_data : 32'h0;
    assign bus.misalign     = w_misalign;
    assign bus.out_of_range = w_out_of_range;
    assign bus.err_sticky   = r_err_sticky;
    assign bus.trace_valid  = r_trace_valid;
    assign bus.trace_pc     = r_trace_pc;
    assign bus.trace_addr   = r_trace_addr;
    assign bus.trace_data   = r_trace_data;
    assign bus.trace_be     = r_trace_be;

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
//==============================================================================
// Module : tb_dm_responder
// Brief  : Scoreboard bench for dm_responder with directed load/store vectors.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_dm_responder;
    import dm_responder_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        oor;
        logic        err;
        logic        tv;
    } comb_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } trace_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    comb_t  q_comb[$];
    trace_t q_trace[$];

    logic        m_sticky;
    logic        m_prev_commit;
    logic [31:0] pc_cnt;

    dm_responder_if bus_if();

    dm_responder #(.DEPTH(3072), .IDX_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Comb/flag monitor: one expectation per driven vector, sampled mid-cycle.
    always @(negedge clk) begin
        if (q_comb.size() > 0) begin
            comb_t e;
            e = q_comb.pop_front();
            chk("rdata",        bus_if.rdata,               e.rdata);
            chk("misalign",     {31'h0, bus_if.misalign},     {31'h0, e.mis});
            chk("out_of_range", {31'h0, bus_if.out_of_range}, {31'h0, e.oor});
            chk("err_sticky",   {31'h0, bus_if.err_sticky},   {31'h0, e.err});
            chk("trace_valid",  {31'h0, bus_if.trace_valid},  {31'h0, e.tv});
        end
    end

    always @(negedge clk) begin
        if (bus_if.trace_valid === 1'b1) begin
            if (q_trace.size() == 0) begin
                chk("unexpected_trace", 32'h1, 32'h0);
            end else begin
                trace_t t;
                t = q_trace.pop_front();
                chk("trace_pc",   bus_if.trace_pc,           t.pc);
                chk("trace_addr", bus_if.trace_addr,         t.addr);
                chk("trace_data", bus_if.trace_data,         t.data);
                chk("trace_be",   {28'h0, bus_if.trace_be},  {28'h0, t.be});
            end
        end
    end

    task automatic apply(input logic we, input logic re, input logic [1:0] op,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic e_mis, input logic e_oor,
                         input logic [31:0] e_trd, input logic [3:0] e_be);
        comb_t  c;
        trace_t t;
        @(posedge clk);
        #1;
        bus_if.pc          = pc_cnt;
        bus_if.addr        = a;
        bus_if.wdata       = wd;
        bus_if.mem_write   = we;
        bus_if.mem_read    = re;
        bus_if.ls_op       = op;
        bus_if.ld_unsigned = uns;
        c.rdata = exp_rd;
        c.mis   = e_mis;
        c.oor   = e_oor;
        c.err   = m_sticky;
        c.tv    = m_prev_commit;
        q_comb.push_back(c);
        if (we && !e_mis && !e_oor) begin
            t.pc   = pc_cnt;
            t.addr = {a[31:2], 2'b00};
            t.data = e_trd;
            t.be   = e_be;
            q_trace.push_back(t);
        end
        m_sticky      = m_sticky | e_mis | e_oor;
        m_prev_commit = we & ~e_mis & ~e_oor;
        pc_cnt        = pc_cnt + 32'd4;
    endtask

    task automatic idle();
        bus_if.mem_write = 1'b0;
        bus_if.mem_read  = 1'b0;
        bus_if.addr      = 32'h0;
        bus_if.wdata     = 32'h0;
        bus_if.ls_op     = c_LS_W;
        bus_if.ld_unsigned = 1'b0;
        bus_if.pc        = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        comb_t c;
        n_vec = 0;
        n_bad = 0;
        m_sticky = 1'b0;
        m_prev_commit = 1'b0;
        pc_cnt = 32'h0040_0000;
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_trace_pc",   bus_if.trace_pc,   32'h0);
        chk("rst_trace_addr", bus_if.trace_addr, 32'h0);
        chk("rst_trace_data", bus_if.trace_data, 32'h0);
        chk("rst_trace_be",   {28'h0, bus_if.trace_be}, 32'h0);

        //    we    re    op      uns   addr          wdata         rdata         mis   oor   trace data    be
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_0004, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        4'h0);
        apply(1'b1, 1'b0, c_LS_W, 1'b0, 32'h0000_0004, 32'h12345678, 32'h0,        1'b0, 1'b0, 32'h12345678, 4'hF);
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_0004, 32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0,        4'h0);
        apply(1'b1, 1'b0, c_LS_B, 1'b0, 32'h0000_0007, 32'h123456AB, 32'h0,        1'b0, 1'b0, 32'hAB345678, 4'h8);
        apply(1'b0, 1'b1, c_LS_B, 1'b0, 32'h0000_0007, 32'h0,        32'hFFFFFFAB, 1'b0, 1'b0, 32'h0,        4'h0);
        apply(1'b0, 1'b1, c_LS_B, 1'b1, 32'h0000_0007, 32'h0,        32'h000000AB, 1'b0, 1'b0, 32'h0,        4'h0);
        apply(1'b1, 1'b0, c_LS_H, 1'b0, 32'h0000_000A, 32'h55558001, 32'h0,        1'b0, 1'b0, 32'h80010000, 4'hC);
        apply(1'b0, 1'b1, c_LS_H, 1'b0, 32'h0000_000A, 32'h0,        32'hFFFF8001, 1'b0, 1'b0, 32'h0,        4'h0);
        apply(1'b0, 1'b1, c_LS_H, 1'b1, 32'h0000_000A, 32'h0,        32'h00008001, 1'b0, 1'b0, 32'h0,        4'h0);
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_0008, 32'h0,        32'h80010000, 1'b0, 1'b0, 32'h0,        4'h0);
        // Misaligned stores: flagged, no write, no trace.
        apply(1'b1, 1'b0, c_LS_W, 1'b0, 32'h0000_0002, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'h0,        4'h0);
        apply(1'b1, 1'b0, c_LS_H, 1'b0, 32'h0000_0003, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 32'h0,        4'h0);
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        4'h0);
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_0004, 32'h0,        32'hAB345678, 1'b0, 1'b0, 32'h0,        4'h0);
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_0006, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        4'h0);
        // Out of range: index 3072 and a high address bit.
        apply(1'b1, 1'b0, c_LS_W, 1'b0, 32'h0000_3000, 32'h77777777, 32'h0,        1'b0, 1'b1, 32'h0,        4'h0);
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_3000, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        4'h0);
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h8000_0004, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        4'h0);
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_2FFC, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        4'h0);
        // Load and store together: load sees the pre-store word.
        apply(1'b1, 1'b1, c_LS_W, 1'b0, 32'h0000_0004, 32'hCAFEF00D, 32'hAB345678, 1'b0, 1'b0, 32'hCAFEF00D, 4'hF);
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_0004, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        4'h0);
        // Back-to-back lane accumulation into one word.
        apply(1'b1, 1'b0, c_LS_B, 1'b0, 32'h0000_0010, 32'h00000011, 32'h0,        1'b0, 1'b0, 32'h00000011, 4'h1);
        apply(1'b1, 1'b0, c_LS_B, 1'b0, 32'h0000_0011, 32'h00000022, 32'h0,        1'b0, 1'b0, 32'h00002211, 4'h2);
        apply(1'b1, 1'b0, c_LS_H, 1'b0, 32'h0000_0012, 32'h00004433, 32'h0,        1'b0, 1'b0, 32'h44332211, 4'hC);
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_0010, 32'h0,        32'h44332211, 1'b0, 1'b0, 32'h0,        4'h0);
        apply(1'b0, 1'b1, c_LS_B, 1'b1, 32'h0000_0012, 32'h0,        32'h00000033, 1'b0, 1'b0, 32'h0,        4'h0);

        // Asynchronous reset between edges while a store and load are presented.
        @(posedge clk);
        #1;
        bus_if.pc        = pc_cnt;
        bus_if.addr      = 32'h0000_0004;
        bus_if.wdata     = 32'hDEADBEEF;
        bus_if.mem_write = 1'b1;
        bus_if.mem_read  = 1'b1;
        bus_if.ls_op     = c_LS_W;
        bus_if.ld_unsigned = 1'b0;
        #1 reset = 1'b1;
        c.rdata = 32'h0;
        c.mis   = 1'b0;
        c.oor   = 1'b0;
        c.err   = 1'b0;
        c.tv    = 1'b0;
        q_comb.push_back(c);
        #1;
        chk("async_trace_valid", {31'h0, bus_if.trace_valid}, 32'h0);
        chk("async_trace_pc",    bus_if.trace_pc,   32'h0);
        chk("async_trace_addr",  bus_if.trace_addr, 32'h0);
        chk("async_trace_data",  bus_if.trace_data, 32'h0);
        chk("async_trace_be",    {28'h0, bus_if.trace_be}, 32'h0);
        chk("async_err_sticky",  {31'h0, bus_if.err_sticky}, 32'h0);
        chk("async_rdata",       bus_if.rdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        m_sticky      = 1'b0;
        m_prev_commit = 1'b0;

        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_0004, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        4'h0);
        apply(1'b0, 1'b1, c_LS_W, 1'b0, 32'h0000_0010, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        4'h0);
        @(posedge clk);
        #1 idle();
        m_prev_commit = 1'b0;

        for (int k = 0; k < 20; k++) begin
            if (q_comb.size() == 0 && q_trace.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        chk("pending_comb",  q_comb.size(),  32'h0);
        chk("pending_trace", q_trace.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data memory for the single-cycle MIPS datapath; the responder to the load/store controls produced by instruction decode (mem_write, LS_op, load sign select).
- Stores word, half and byte lanes with a synchronous read-modify-write; returns loads combinationally with sign or zero extension.
- Flags misaligned and out-of-range accesses.
- Registers a one-cycle write trace (pc, word address, merged word, byte enables) that the bench uses to check against the reference simulator.

Parameters:
- DEPTH, 3072: number of 32-bit words (byte range 0x0000..0x2FFF).
- IDX_W, 12: word-index width; must satisfy 2^IDX_W >= DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears the array, the trace and err_sticky.
- pc  in  32  PC of the current instruction; used for the trace only.
- addr  in  32  byte address, i.e. the ALU result.
- wdata  in  32  store data (GPR[rt]); the low bytes are used for sh/sb.
- mem_write  in  1  store request this cycle.
- mem_read  in  1  load request this cycle.
- ls_op  in  2  access size: LS_w, LS_h or LS_b (header encodings).
- ld_unsigned  in  1  1 = zero-extend the load (lhu/lbu); 0 = sign-extend.
- rdata  out  32  extended load data; combinational.
- misalign  out  1  current access is misaligned; combinational.
- out_of_range  out  1  current access has word index >= DEPTH; combinational.
- err_sticky  out  1  set on any faulting access; cleared only by reset.
- trace_valid  out  1  registered; 1 for exactly the cycle after a committed store.
- trace_pc  out  32  registered pc of that store.
- trace_addr  out  32  registered word-aligned address, {addr[31:2],2'b00}.
- trace_data  out  32  registered merged word as written to the array.
- trace_be  out  4  registered byte enables of that store.

Behaviour:
- Word index = addr[IDX_W+1:2].
- Byte lane = addr[1:0]. Lane 0 is bits [7:0] (little-endian).
- out_of_range = (mem_write|mem_read) & (addr[31:IDX_W+2] != 0 | index >= DEPTH).
- misalign = (mem_write|mem_read) & ((ls_op==LS_w & addr[1:0]!=0) | (ls_op==LS_h & addr[0])).
- Byte enables:
  - LS_w: 4'b1111.
  - LS_h: 4'b0011 << addr[1:0].
  - LS_b: 4'b0001 << addr[1:0].
  - Undefined ls_op behaves as LS_w.
- Merged word: each enabled lane takes the matching lane of the shifted store data (wdata[15:0] for half, wdata[7:0] for byte, placed at the lane); other lanes keep the old word.
- Commit = mem_write & ~misalign & ~out_of_range.
- On a posedge with commit, mem[index] <= merged word. The write is visible to rdata from the next cycle; a same-cycle load sees the old contents.
- A faulting store never modifies the array.
- Load path (combinational):
  - Select the word, then the lane or half selected by addr.
  - Extend per ld_unsigned.
  - rdata = 0 when out_of_range, misalign or ~mem_read.
- Trace registers, each posedge:
  - trace_valid <= commit.
  - On commit, trace_pc/trace_addr/trace_data/trace_be load their new values.
  - Otherwise those four fields hold their previous values.
- err_sticky <= err_sticky | misalign | out_of_range. Updated on every posedge.
- Reset (asynchronous, asserted at any time, including mid-store):
  - All mem words = 0.
  - trace_valid = 0; trace_pc, trace_addr, trace_data = 0; trace_be = 0.
  - err_sticky = 0.
  - A store whose clock edge coincides with reset asserted is discarded.
- mem_write and mem_read both high: the store commits and the load returns the pre-store word.
- Back-to-back stores to the same word accumulate lanes across consecutive cycles.

Decomposition:
- Shared header (existing): LS_w, LS_h, LS_b encodings; DM base address; DEPTH default.
- Sub-module dm_load_ext (combinational):
  - Inputs: word, addr[1:0], ls_op, ld_unsigned.
  - Output: 32-bit extended data.
  - Reused by a later pipelined MEM stage.
- The byte-enable/merge logic stays inline.

Test Plan:
- Reset, then store word 0x12345678 at 0x0004 -> next cycle trace_valid=1, trace_addr=0x4, trace_data=0x12345678, trace_be=4'hF; load word at 0x0004 -> rdata 0x12345678.
- sb 0xAB at 0x0007 over 0x12345678 -> trace_data 0xAB345678, trace_be 4'h8; lb at 0x0007 -> 0xFFFFFFAB; lbu -> 0x000000AB.
- sh 0x8001 at 0x000A over 0 -> word 0x80010000, trace_be 4'hC; lh -> 0xFFFF8001; lhu -> 0x00008001.
- sw at 0x0002 and sh at 0x0003 -> misalign=1, array unchanged, trace_valid=0, err_sticky=1 until reset.
- Store to 0x3000 (index 3072) -> out_of_range=1, no write; load there -> rdata 0.
- Assert reset between two clock edges after writes -> immediately all trace outputs and err_sticky are 0; load at 0x0004 -> 0.
